// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame limits,
// parity/stop encodings and small frame-geometry helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_PARITY  = 3'd3,
      ST_STOP1   = 3'd4,
      ST_STOP2   = 3'd5,
      ST_BRKWAIT = 3'd6
   } rx_state_e;

   localparam int unsigned DATA_BITS_MIN = 5;
   localparam int unsigned DATA_BITS_MAX = 8;

   localparam logic PAR_EVEN = 1'b1;
   localparam logic PAR_ODD  = 1'b0;

   localparam logic STOP2 = 1'b1;
   localparam logic STOP1 = 1'b0;

   // Frame configuration captured at start detection.
   typedef struct packed {
      logic [1:0]  data_bits;
      logic        stop2;
      logic        par_en;
      logic        par_even;
      logic [15:0] divisor;
   } rx_cfg_t;

   // Full-bit reload: 2*div+1, so expiry spacing is 2*(div+1).
   function automatic logic [16:0] bit_reload(
      input logic [15:0] div
   );
      return {div, 1'b1};
   endfunction

   // Index of the final data bit for a data_bits code.
   function automatic logic [2:0] last_idx(
      input logic [1:0] db
   );
      return 3'(db) + 3'(DATA_BITS_MIN - 1);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter giving one expiry pulse per sample point.
// Ports: clk_i/rst_i, load_i + load_val_i (17b), run_i, expire_o.
module uart_bit_timer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [16:0] load_val_i,
   input  logic        run_i,
   output logic        expire_o
);

   // 17 bits wide so 2*div+1 never overflows.
   logic [16:0] cnt_q;
   logic [16:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (run_i && cnt_q != '0) begin
         cnt_d = cnt_q - 17'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A load of N expires N+1 clocks after the loading edge.
   assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 5-8 data bits, optional parity, 1/2 stop bits.
// Ports: mclk/rst, rxd, cfg_* frame setup, rx_* char + status out
// with rx_valid/rx_ready handshake, rx_overrun pulse, rx_busy.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        mclk,
   input  logic        rst,
   input  logic        rxd,
   input  logic [1:0]  cfg_data_bits,
   input  logic        cfg_stop2,
   input  logic        cfg_par_en,
   input  logic        cfg_par_even,
   input  logic [15:0] cfg_divisor,
   output logic [7:0]  rx_data,
   output logic        rx_par_err,
   output logic        rx_frm_err,
   output logic        rx_break,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        rx_overrun,
   output logic        rx_busy
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic                   rxs_prev_q;
   logic                   start_det;

   rx_state_e   state_q, state_d;
   rx_cfg_t     cfg_q, cfg_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        perr_q, perr_d;
   logic        ferr_q, ferr_d;
   logic        zero_q, zero_d;

   logic [7:0]  data_q, data_d;
   logic        operr_q, operr_d;
   logic        oferr_q, oferr_d;
   logic        obrk_q, obrk_d;
   logic        valid_q, valid_d;
   logic        ovr_q, ovr_d;

   logic        running;
   logic        tick;
   logic        tmr_load;
   logic [16:0] tmr_val;
   logic        complete;
   logic        brk;
   logic        par_exp;

   // Preset to idle-high so reset never fakes a start edge.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         sync_q     <= '1;
         rxs_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
         rxs_prev_q <= rxs;
      end
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   assign start_det = (state_q == ST_IDLE)
                    & rxs_prev_q & ~rxs;

   assign running = (state_q != ST_IDLE)
                  && (state_q != ST_BRKWAIT);

   uart_bit_timer u_timer (
      .clk_i      (mclk),
      .rst_i      (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .run_i      (running),
      .expire_o   (tick)
   );

   assign par_exp = (cfg_q.par_even == PAR_EVEN)
                  ? par_q : ~par_q;

   always_comb begin
      state_d  = state_q;
      cfg_d    = cfg_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      par_d    = par_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      zero_d   = zero_q;
      data_d   = data_q;
      operr_d  = operr_q;
      oferr_d  = oferr_q;
      obrk_d   = obrk_q;
      valid_d  = valid_q & ~rx_ready;
      ovr_d    = 1'b0;
      complete = 1'b0;
      brk      = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = bit_reload(cfg_q.divisor);

      unique case (state_q)
         ST_IDLE: begin
            if (start_det) begin
               state_d         = ST_START;
               cfg_d.data_bits = cfg_data_bits;
               cfg_d.stop2     = cfg_stop2;
               cfg_d.par_en    = cfg_par_en;
               cfg_d.par_even  = cfg_par_even;
               cfg_d.divisor   = cfg_divisor;
               idx_d           = '0;
               shift_d         = '0;
               par_d           = 1'b0;
               perr_d          = 1'b0;
               ferr_d          = 1'b0;
               zero_d          = 1'b1;
               // First expiry lands mid start bit.
               tmr_load        = 1'b1;
               tmr_val         = {1'b0, cfg_divisor};
            end
         end
         ST_START: begin
            if (tick) begin
               tmr_load = 1'b1;
               state_d  = rxs ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               tmr_load       = 1'b1;
               shift_d[idx_q] = rxs;
               par_d          = par_q ^ rxs;
               idx_d          = idx_q + 3'd1;
               if (idx_q == last_idx(cfg_q.data_bits)) begin
                  state_d = cfg_q.par_en ? ST_PARITY
                                         : ST_STOP1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               tmr_load = 1'b1;
               perr_d   = rxs ^ par_exp;
               zero_d   = zero_q & ~rxs;
               state_d  = ST_STOP1;
            end
         end
         ST_STOP1: begin
            if (tick) begin
               tmr_load = 1'b1;
               ferr_d   = ferr_q | ~rxs;
               zero_d   = zero_q & ~rxs;
               if (cfg_q.stop2 == STOP2) begin
                  state_d = ST_STOP2;
               end else begin
                  complete = 1'b1;
               end
            end
         end
         ST_STOP2: begin
            if (tick) begin
               tmr_load = 1'b1;
               ferr_d   = ferr_q | ~rxs;
               zero_d   = zero_q & ~rxs;
               complete = 1'b1;
            end
         end
         ST_BRKWAIT: begin
            // Hold off until the line recovers.
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (complete) begin
         // zero_d already folds in this stop sample.
         brk     = (shift_q == '0) & zero_d;
         state_d = brk ? ST_BRKWAIT : ST_IDLE;
         // Same-clock accept frees the holding register.
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            operr_d = perr_q;
            oferr_d = ferr_d;
            obrk_d  = brk;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cfg_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         zero_q  <= 1'b0;
         data_q  <= '0;
         operr_q <= 1'b0;
         oferr_q <= 1'b0;
         obrk_q  <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         zero_q  <= zero_d;
         data_q  <= data_d;
         operr_q <= operr_d;
         oferr_q <= oferr_d;
         obrk_q  <= obrk_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_data    = data_q;
   assign rx_par_err = operr_q;
   assign rx_frm_err = oferr_q;
   assign rx_break   = obrk_q;
   assign rx_valid   = valid_q;
   assign rx_overrun = ovr_q;
   assign rx_busy    = (state_q != ST_IDLE);

endmodule
